// File: rtl/demux_scan_checker.sv
// demux_scan_checker: scans a 1x16 demultiplexer under test.
// Each valid sample is compared against the ideal demux output.
// Pass and fail counts and a 32-entry coverage mask are kept for each sample.
// The first failing {exp_a,exp_sel} index is recorded.
// The scan completes once every {exp_a,exp_sel} combination has been seen.
module demux_scan_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             exp_a,
    input  logic [3:0]       exp_sel,
    input  logic [15:0]      y_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [31:0]      cov_mask,
    output logic             err,
    output logic [4:0]       first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state;
    state_t      state_next;
    logic [4:0]  idx;
    logic [15:0] expected;
    logic        match;
    logic        sample;
    logic [31:0] cov_next;

    assign idx      = {exp_a, exp_sel};
    assign expected = exp_a ? (16'h0001 << exp_sel) : 16'h0000;
    assign match    = (y_in == expected);
    assign sample   = (state == RUN) && in_valid;
    assign cov_next = cov_mask | (32'h0000_0001 << idx);

    // Next-state logic: the scan ends on the sample that completes coverage.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (sample && (cov_next == 32'hFFFF_FFFF)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; busy and done are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Scan results: cleared on an accepted start, updated per valid sample, held otherwise.
    always_ff @(posedge clk) begin
        if (rst || ((state == IDLE) && start)) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            cov_mask       <= '0;
            err            <= 1'b0;
            first_fail_idx <= '0;
        end else if (sample) begin
            cov_mask <= cov_next;
            if (match) begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
            end else begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
                if (!err) begin
                    err            <= 1'b1;
                    first_fail_idx <= idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_scan_checker.sv
// tb_demux_scan_checker: directed scenarios with a done-triggered scoreboard.
// Stimulus pushes the expected end-of-scan result into a queue.
// A monitor pops and checks that entry whenever done pulses.
// Mid-scan and idle states are checked directly after the relevant sample.
module tb_demux_scan_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        exp_a = 1'b0;
    logic [3:0]  exp_sel = 4'd0;
    logic [15:0] y_in = 16'd0;

    logic        busy, done, err;
    logic [7:0]  pass_cnt, fail_cnt;
    logic [31:0] cov_mask;
    logic [4:0]  first_fail_idx;

    logic        busy4, done4, err4;
    logic [3:0]  pass_cnt4, fail_cnt4;
    logic [31:0] cov_mask4;
    logic [4:0]  first_fail_idx4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          pass;
        int          fail;
        logic        err;
        int          ffi;
        logic [31:0] cov;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    demux_scan_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .exp_a(exp_a), .exp_sel(exp_sel), .y_in(y_in),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .cov_mask(cov_mask), .err(err), .first_fail_idx(first_fail_idx)
    );

    demux_scan_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .exp_a(exp_a), .exp_sel(exp_sel), .y_in(y_in),
        .busy(busy4), .done(done4), .pass_cnt(pass_cnt4), .fail_cnt(fail_cnt4),
        .cov_mask(cov_mask4), .err(err4), .first_fail_idx(first_fail_idx4)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to pin down when done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] expY(input logic [4:0] idx);
        logic [15:0] one = 16'h0001;
        return idx[4] ? (one << idx[3:0]) : 16'h0000;
    endfunction

    task automatic applyStimulus(input logic s, input logic v, input logic [4:0] idx, input logic [15:0] y);
        @(negedge clk);
        start    = s;
        in_valid = v;
        exp_a    = idx[4];
        exp_sel  = idx[3:0];
        y_in     = y;
    endtask

    task automatic checkOutput(input string tag, input int p, input int f, input logic [31:0] cov,
                               input logic e, input int ff, input logic b);
        checkVal({tag, "_pass"}, 32'(pass_cnt), 32'(p));
        checkVal({tag, "_fail"}, 32'(fail_cnt), 32'(f));
        checkVal({tag, "_cov"}, cov_mask, cov);
        checkVal({tag, "_err"}, 32'(err), 32'(e));
        checkVal({tag, "_ffi"}, 32'(first_fail_idx), 32'(ff));
        checkVal({tag, "_busy"}, 32'(busy), 32'(b));
        checkVal({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Full 32-sample sweep; optional bad sample and start asserted mid-scan.
    task automatic runSweep(input int bad_idx, input logic [15:0] bad_y, input bit noisy);
        exp_t e;
        logic [15:0] y;
        applyStimulus(1'b1, noisy, 5'd31, 16'h0000);
        for (int i = 0; i < 32; i++) begin
            y = (i == bad_idx) ? bad_y : expY(5'(i));
            applyStimulus(noisy && (i >= 5) && (i <= 8), 1'b1, 5'(i), y);
        end
        e.pass = (bad_idx >= 0) ? 31 : 32;
        e.fail = (bad_idx >= 0) ? 1 : 0;
        e.err  = (bad_idx >= 0);
        e.ffi  = (bad_idx >= 0) ? bad_idx : 0;
        e.cov  = 32'hFFFF_FFFF;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        while (sb.size() != 0 && n < 20) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
            n++;
        end
        checkVal({tag, "_done_seen"}, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest expected scan result.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkVal("mon_pass", 32'(pass_cnt), 32'(e.pass));
                checkVal("mon_fail", 32'(fail_cnt), 32'(e.fail));
                checkVal("mon_err", 32'(err), 32'(e.err));
                checkVal("mon_ffi", 32'(first_fail_idx), 32'(e.ffi));
                checkVal("mon_cov", cov_mask, e.cov);
                checkVal("mon_cycle", 32'(cyc), 32'(e.cyc));
                checkVal("mon_busy", 32'(busy), 32'd0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        doReset();
        checkOutput("reset", 0, 0, 32'h0, 1'b0, 0, 1'b0);
        checkVal("reset_fail4", 32'(fail_cnt4), 32'd0);

        runSweep(-1, 16'h0000, 1'b0);
        waitDrain("clean");
        checkOutput("clean_hold", 32, 0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        checkVal("clean_pass4_sat", 32'(pass_cnt4), 32'd15);

        runSweep(21, 16'h0000, 1'b0);
        waitDrain("bad21");
        checkOutput("bad21_hold", 31, 1, 32'hFFFF_FFFF, 1'b1, 21, 1'b0);

        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0000);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 16; i++)
                applyStimulus(1'b0, 1'b1, 5'(i), 16'h0000);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        checkOutput("half", 32, 0, 32'h0000_FFFF, 1'b0, 0, 1'b1);
        doReset();
        checkOutput("half_reset", 0, 0, 32'h0, 1'b0, 0, 1'b0);

        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0000);
        for (int k = 0; k < 20; k++)
            applyStimulus(1'b0, 1'b1, 5'((7 + k) % 32), 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        checkVal("sat_fail4", 32'(fail_cnt4), 32'd15);
        checkVal("sat_ffi4", 32'(first_fail_idx4), 32'd7);
        checkVal("sat_err4", 32'(err4), 32'd1);
        checkVal("sat_fail8", 32'(fail_cnt), 32'd20);
        checkVal("sat_busy", 32'(busy), 32'd1);
        doReset();

        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0000);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b1, 5'(i), expY(5'(i)));
        doReset();
        checkOutput("midrun_reset", 0, 0, 32'h0, 1'b0, 0, 1'b0);
        runSweep(-1, 16'h0000, 1'b0);
        waitDrain("after_reset");

        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b1, 5'(i + 16), 16'h0000);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        checkOutput("idle_valid", 32, 0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        runSweep(-1, 16'h0000, 1'b1);
        waitDrain("noisy");

        checkVal("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
